// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX->MEM pipeline bus carrying ALU results, controls and stage outputs.
//   master: EX side / driver (drives stall, flush, in_*; observes out_*, branch_taken, nzcv)
//   slave : the ex_mem_stage register (consumes in_*, produces out_*, branch_taken, nzcv)
interface ex_mem_stage_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     in_result;
  logic                      in_negative;
  logic                      in_zero;
  logic                      in_overflow;
  logic                      in_carry_out;
  logic                      in_set_flags;
  logic                      in_is_bcond;
  logic                      in_is_cbz;
  logic [3:0]                in_cond;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      in_reg_write;
  logic                      in_mem_read;
  logic                      in_mem_write;
  logic [DATA_WIDTH-1:0]     in_store_data;
  logic                      out_valid;
  logic [DATA_WIDTH-1:0]     out_result;
  logic [DATA_WIDTH-1:0]     out_store_data;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_reg_write;
  logic                      out_mem_read;
  logic                      out_mem_write;
  logic                      branch_taken;
  logic [3:0]                nzcv;
  modport master (
    output stall, flush, in_valid, in_result, in_negative, in_zero, in_overflow, in_carry_out,
           in_set_flags, in_is_bcond, in_is_cbz, in_cond, in_rd, in_reg_write, in_mem_read,
           in_mem_write, in_store_data,
    input  out_valid, out_result, out_store_data, out_rd, out_reg_write, out_mem_read,
           out_mem_write, branch_taken, nzcv
  );
  modport slave (
    input  stall, flush, in_valid, in_result, in_negative, in_zero, in_overflow, in_carry_out,
           in_set_flags, in_is_bcond, in_is_cbz, in_cond, in_rd, in_reg_write, in_mem_read,
           in_mem_write, in_store_data,
    output out_valid, out_result, out_store_data, out_rd, out_reg_write, out_mem_read,
           out_mem_write, branch_taken, nzcv
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register owning NZCV and the registered branch decision.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ex_mem_stage_if.slave (stall/flush, in_* from EX, out_*/branch_taken/nzcv to MEM)
//   STAGE_PERF_EN (macro): adds saturating perf_instr_cnt / perf_stall_cnt outputs
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef STAGE_PERF_EN
  output logic [CNT_WIDTH-1:0] perf_instr_cnt,
  output logic [CNT_WIDTH-1:0] perf_stall_cnt,
`endif
  ex_mem_stage_if.slave        bus
);
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d, store_q, store_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
  logic                      bt_q, bt_d;
  logic [3:0]                nzcv_q, nzcv_d;
  logic                      accept, hold, take_valid;
  logic                      n, z, c, v, ge, cond_ok;
  logic [7:0]                cond_base;
  assign accept     = !bus.flush && !bus.stall;
  assign hold       = bus.stall && !bus.flush;
  assign take_valid = accept && bus.in_valid;
  assign {n, z, c, v} = nzcv_q;
  assign ge = n == v;
  // Even codes test the flag expression, odd codes its inverse; 111x is always taken.
  assign cond_base = {1'b1, !z && ge, ge, c && !z, v, n, c, z};
  assign cond_ok   = (&bus.in_cond[3:1]) || (cond_base[bus.in_cond[3:1]] ^ bus.in_cond[0]);
  always_comb begin
    valid_d  = bus.flush ? 1'b0 : bus.stall ? valid_q : bus.in_valid;
    result_d = bus.flush ? '0 : bus.stall ? result_q : bus.in_result;
    store_d  = bus.flush ? '0 : bus.stall ? store_q : bus.in_store_data;
    rd_d     = bus.flush ? '0 : bus.stall ? rd_q : bus.in_rd;
    rw_d     = bus.flush ? 1'b0 : bus.stall ? rw_q : bus.in_valid && bus.in_reg_write;
    mr_d     = bus.flush ? 1'b0 : bus.stall ? mr_q : bus.in_valid && bus.in_mem_read;
    mw_d     = bus.flush ? 1'b0 : bus.stall ? mw_q : bus.in_valid && bus.in_mem_write;
    // Branch uses the flags registered before this edge, so a flag-setting B.cond sees old NZCV.
    bt_d     = bus.flush ? 1'b0 : bus.stall ? bt_q :
               bus.in_valid && (bus.in_is_cbz ? bus.in_zero : bus.in_is_bcond && cond_ok);
    nzcv_d   = (take_valid && bus.in_set_flags) ?
               {bus.in_negative, bus.in_zero, bus.in_carry_out, bus.in_overflow} : nzcv_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      bt_q     <= 1'b0;
      nzcv_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      bt_q     <= bt_d;
      nzcv_q   <= nzcv_d;
    end
  end
  assign bus.out_valid      = valid_q;
  assign bus.out_result     = result_q;
  assign bus.out_store_data = store_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_reg_write  = rw_q;
  assign bus.out_mem_read   = mr_q;
  assign bus.out_mem_write  = mw_q;
  assign bus.branch_taken   = bt_q;
  assign bus.nzcv           = nzcv_q;
`ifdef STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    instr_cnt_d = (take_valid && !(&instr_cnt_q)) ? instr_cnt_q + 1'b1 : instr_cnt_q;
    stall_cnt_d = (hold && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign perf_instr_cnt = instr_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register sitting directly downstream of the 64-bit ALU, between EX and MEM.
- Captures the ALU result and control bits for MEM/WB.
- Owns the architectural NZCV flag register, written by flag-setting ops (ADDS/SUBS).
- Produces a registered branch-taken decision for B.cond and CBZ.

Parameters:
- DATA_WIDTH, 64, width of result and store data.
- REG_ADDR_WIDTH, 5, width of destination register index.
- CNT_WIDTH, 32, width of perf counters (only used with STAGE_PERF_EN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold stage contents; incoming instruction not accepted.
- flush  input  1  replace incoming instruction with a bubble.
- in_valid  input  1  EX holds a real instruction.
- in_result  input  DATA_WIDTH  ALU result.
- in_negative, in_zero, in_overflow, in_carry_out  input  1 each  ALU flags.
- in_set_flags  input  1  instruction updates NZCV.
- in_is_bcond  input  1  instruction is B.cond.
- in_is_cbz  input  1  instruction is CBZ (ALU passes B; in_zero = operand is zero).
- in_cond  input  4  LEGv8 condition code.
- in_rd  input  REG_ADDR_WIDTH  destination register.
- in_reg_write, in_mem_read, in_mem_write  input  1 each  control bits.
- in_store_data  input  DATA_WIDTH  data for STUR.
- out_valid  output  1  stage holds a real instruction.
- out_result, out_store_data  output  DATA_WIDTH  registered copies.
- out_rd  output  REG_ADDR_WIDTH  registered copy.
- out_reg_write, out_mem_read, out_mem_write  output  1 each  registered; forced 0 when out_valid=0.
- branch_taken  output  1  registered branch decision for the captured instruction.
- nzcv  output  4  flag register {N,Z,C,V}.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register is 0, including nzcv and counters.
- Latency: one cycle. Inputs sampled on rising clk, visible on outputs after that edge.
- Accept condition, evaluated each rising edge:
  - flush=1 (priority over stall): capture a bubble. out_valid=0, control outputs and branch_taken 0, data outputs don't-care but driven 0. NZCV unchanged.
  - stall=1, flush=0: all registers including NZCV hold their values.
  - otherwise: capture all in_* fields. out_valid=in_valid. If in_valid=0, controls and branch_taken are 0.
- Flag update: nzcv <= {in_negative,in_zero,in_carry_out,in_overflow} only on accept with in_valid=1 and in_set_flags=1.
- branch_taken on accept with in_valid=1:
  - in_is_cbz=1: branch_taken = in_zero. CBZ has priority if both in_is_cbz and in_is_bcond are set.
  - in_is_bcond=1: evaluate in_cond against the current registered nzcv, i.e. the value before this edge's update.
  - neither set: branch_taken = 0.
- Condition decode:
  - 0000 EQ Z; 0001 NE !Z.
  - 0010 HS C; 0011 LO !C.
  - 0100 MI N; 0101 PL !N.
  - 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !(C&!Z).
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE !GT.
  - 1110 and 1111 always taken.
- A flag-setting B.cond uses the old flags for the branch, then updates nzcv.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. The first edge after reset release behaves as a normal accept.

Optional Feature:
- STAGE_PERF_EN defined: adds outputs perf_instr_cnt and perf_stall_cnt, each CNT_WIDTH.
  - perf_instr_cnt increments on each accept with in_valid=1.
  - perf_stall_cnt increments each edge with stall=1 and flush=0.
  - Both saturate at all-ones (no wrap) and reset to 0.
- STAGE_PERF_EN undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 with random inputs, toggle clk -> all outputs 0, nzcv=0000. Release, accept ADD 1+1 (in_result=2, rd=3, reg_write=1) -> next cycle out_valid=1, out_result=2, out_rd=3, nzcv still 0000.
- Flags and B.LT: ADDS with result 0x8000000000000000 (N=1, V=1, C=0, Z=0) -> nzcv=1001. Next, B.cond with in_cond=1011 -> branch_taken=0. Repeat with SUBS giving N=0, V=1 -> nzcv=0011, B.LT -> branch_taken=1.
- Stall: capture result 0x55, then stall=1 for 3 cycles with changing inputs and in_set_flags=1 -> out_result stays 0x55, nzcv unchanged. Release -> new instruction captured.
- Flush priority: stall=1 and flush=1 together with valid SUBS that would set Z -> out_valid=0, out_reg_write=0, branch_taken=0, nzcv unchanged.
- CBZ: in_is_cbz=1 with in_zero=1 -> branch_taken=1. With in_zero=0 -> 0. With in_is_cbz=1, in_is_bcond=1, in_cond=1110, in_zero=0 -> 0 (CBZ priority).
- Perf (STAGE_PERF_EN, CNT_WIDTH=4): 20 valid accepts -> perf_instr_cnt=15, saturated. 2 stall cycles -> perf_stall_cnt=2. Reset -> both 0.
